register_io_bank: RTL and testbench
===================================

// Module: register_io_bank
// PURPOSE
//  Parametrised host register bank: decodes host read/write requests into NUM_REGS local 32-bit
//  settings registers and a NUM_RO-word read-only status window.
//  Rebroadcasts every write on the serial settings bus (strobe_wr/addr_wr/data_wr) for remote setting_reg decode.
//  Sits between the inband packet command decoder and the rx/tx datapath control (thresholds, RSSI, mux).
// PARAMETERS
//  ADDR_W     7         host address width
//  BASE_ADDR  51        address of local settings register 0
//  NUM_REGS   2         local R/W settings registers (1..16)
//  RO_BASE    1         address of read-only word 0
//  NUM_RO     4         read-only status words (1..16)
//  RESET_VAL  32'h0     reset value of every local register
// PORTS
//  clk        in   1               system clock
//  reset      in   1               synchronous, active-high reset
//  req        in   1               access request, sampled in IDLE only
//  we         in   1               1 = write, 0 = read (qualified by req)
//  addr       in   ADDR_W          register address
//  wdata      in   32              write data
//  rdata      out  32              read data, valid while ack=1
//  ack        out  1               one-cycle completion pulse
//  err        out  1               unmapped/illegal access flag, valid while ack=1
//  ro_in      in   NUM_RO*32       status words (word i at bits 32*i+:32), e.g. rssi_0..3
//  regs_out   out  NUM_REGS*32     local register contents (word i at bits 32*i+:32)
//  strobe_wr  out  1               settings-bus write strobe
//  addr_wr    out  ADDR_W          settings-bus address
//  data_wr    out  32              settings-bus data
// BEHAVIOUR
//  Reset: state=IDLE; rdata=0, ack=0, err=0, strobe_wr=0, addr_wr=0, data_wr=0; all regs_out words=RESET_VAL.
//  FSM: IDLE -> ACCESS (req=1 sampled) -> RESP -> IDLE; no other transitions.
//  IDLE: latch addr, we, wdata on req=1; otherwise hold. Outputs ack=0, strobe_wr=0.
//  ACCESS (cycle N+1): write -> if addr in [BASE_ADDR, BASE_ADDR+NUM_REGS) update that reg (visible on regs_out at N+2).
//   Any write: strobe_wr=1 for this cycle only, addr_wr/data_wr=latched values (held until next write).
//   Read: rdata computed and registered: local reg, ro_in word, else 32'hFFFFFFFF.
//  RESP (cycle N+2): ack=1 for one cycle; err=1 if addr hit neither window, or write hit RO window.
//   Write to RO window: no local state change; strobe_wr still pulses.
//  Latency: req accepted at N -> ack at N+2; next req accepted earliest at N+3. req in ACCESS/RESP ignored, not queued.
//  Overlapping windows are illegal config: local regs take read priority (elaboration check recommended).
//  Address compare is unsigned at full ADDR_W; index = addr - base, truncated to $clog2(count).
//  rdata holds last read value until the next read; write responses leave rdata unchanged.
//  Reset mid-operation: abort to IDLE, no ack, no strobe in the following cycle; pending write lost.
// CONFIGURATION
//  REGIO_ERR_CNT_EN defined: 16-bit saturating counter of err responses (sat at 16'hFFFF), incremented at RESP
//   whenever err=1. Readable at address BASE_ADDR+NUM_REGS (then not unmapped). A write of any data to that
//   address clears it to 0 (err=0). Reset clears it to 0.
//  REGIO_ERR_CNT_EN undefined: no counter; that address is unmapped (read FFFFFFFF, err=1).
// STRUCTURE
//  Package regio_pkg: state enum (IDLE, ACCESS, RESP), RD_UNMAPPED=32'hFFFFFFFF, ERR_CNT_W=16.
//  Sub-module register_io_decode: combinational addr -> {hit_local, hit_ro, hit_errcnt, index}.
//  Top: FSM, register array, readback mux, settings-bus outputs.
// TESTING (BASE_ADDR=51, NUM_REGS=2, RO_BASE=1, NUM_RO=4)
//  1 Reset then read 51 -> ack at +2, rdata=00000000, err=0; regs_out all 0.
//  2 Write 52=DEADBEEF -> strobe_wr 1 cycle, addr_wr=52, data_wr=DEADBEEF; read 52 -> DEADBEEF.
//  3 ro_in word2=12345678, read 3 -> 12345678 err=0; write 3=0 -> err=1, read 3 still 12345678.
//  4 Read 60 -> rdata=FFFFFFFF err=1; write 60=5 -> strobe_wr pulses addr_wr=60, regs unchanged.
//  5 Write 51=1; assert reset during ACCESS -> no ack, regs_out word0=0; req held in ACCESS/RESP gives one ack only.
//  6 REGIO_ERR_CNT_EN: 3 unmapped reads, read 53 -> 00000003; write 53 -> read 53 = 0. Without: read 53 -> FFFFFFFF err=1.

Source files
------------

// File: rtl/regio_pkg.sv
// Shared types and constants for the host register bank.
// REGIO_ERR_CNT_EN (optional) enables the error-response counter in register_io_bank.
package regio_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    localparam logic [31:0] RD_UNMAPPED = 32'hFFFF_FFFF;
    localparam int unsigned ERR_CNT_W   = 16;

    // Index width for a window of n words; at least one bit so ports stay legal for n == 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/register_io_decode.sv
// Combinational address decode into local settings, read-only status and error-counter windows.
// The error-counter hit exists only when REGIO_ERR_CNT_EN is defined.
module register_io_decode
    import regio_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned BASE_ADDR   = 51,
    parameter int unsigned NUM_REGS    = 2,
    parameter int unsigned RO_BASE     = 1,
    parameter int unsigned NUM_RO      = 4,
    parameter int unsigned LOCAL_IDX_W = idx_width(NUM_REGS),
    parameter int unsigned RO_IDX_W    = idx_width(NUM_RO)
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic                   hit_local,
    output logic                   hit_ro,
    output logic                   hit_errcnt,
    output logic [LOCAL_IDX_W-1:0] local_idx,
    output logic [RO_IDX_W-1:0]    ro_idx
);

    logic [31:0] addr_ext;
    logic [31:0] local_off;
    logic [31:0] ro_off;

    assign addr_ext  = 32'(addr);
    assign local_off = addr_ext - BASE_ADDR;
    assign ro_off    = addr_ext - RO_BASE;

    assign hit_local = (addr_ext >= BASE_ADDR) && (addr_ext < BASE_ADDR + NUM_REGS);
    assign hit_ro    = (addr_ext >= RO_BASE) && (addr_ext < RO_BASE + NUM_RO);
    assign local_idx = local_off[LOCAL_IDX_W-1:0];
    assign ro_idx    = ro_off[RO_IDX_W-1:0];

`ifdef REGIO_ERR_CNT_EN
    // Lowest priority: only claims the address if no real window does.
    assign hit_errcnt = !hit_local && !hit_ro && (addr_ext == BASE_ADDR + NUM_REGS);
`else
    assign hit_errcnt = 1'b0;
`endif

    if ((BASE_ADDR < RO_BASE + NUM_RO) && (RO_BASE < BASE_ADDR + NUM_REGS)) begin : g_overlap
        $error("register_io_decode: local and read-only windows overlap");
    end

endmodule

// File: rtl/register_io_bank.sv
// Host register bank: local settings registers, read-only status window and settings-bus echo.
// Define REGIO_ERR_CNT_EN to add a saturating err-response counter at BASE_ADDR+NUM_REGS.
module register_io_bank
    import regio_pkg::*;
#(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned BASE_ADDR = 51,
    parameter int unsigned NUM_REGS  = 2,
    parameter int unsigned RO_BASE   = 1,
    parameter int unsigned NUM_RO    = 4,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ack,
    output logic                   err,
    input  logic [NUM_RO*32-1:0]   ro_in,
    output logic [NUM_REGS*32-1:0] regs_out,
    output logic                   strobe_wr,
    output logic [ADDR_W-1:0]      addr_wr,
    output logic [31:0]            data_wr
);

    localparam int unsigned LocalIdxW = idx_width(NUM_REGS);
    localparam int unsigned RoIdxW    = idx_width(NUM_RO);

    state_e state_q, state_d;

    logic [ADDR_W-1:0]    addr_q;
    logic                 we_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q;
    logic [31:0]          rdata_d;
    logic                 err_q;
    logic                 err_d;
    logic [ADDR_W-1:0]    addr_wr_q;
    logic [31:0]          data_wr_q;
    logic [31:0]          regs_q [NUM_REGS];
    logic [31:0]          ro_words [NUM_RO];
    logic [ERR_CNT_W-1:0] err_cnt;

    logic                 hit_local;
    logic                 hit_ro;
    logic                 hit_errcnt;
    logic [LocalIdxW-1:0] local_idx;
    logic [RoIdxW-1:0]    ro_idx;

    // Decode always looks at the latched address, so it is stable through ACCESS.
    register_io_decode #(
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE_ADDR),
        .NUM_REGS   (NUM_REGS),
        .RO_BASE    (RO_BASE),
        .NUM_RO     (NUM_RO),
        .LOCAL_IDX_W(LocalIdxW),
        .RO_IDX_W   (RoIdxW)
    ) u_decode (
        .addr      (addr_q),
        .hit_local (hit_local),
        .hit_ro    (hit_ro),
        .hit_errcnt(hit_errcnt),
        .local_idx (local_idx),
        .ro_idx    (ro_idx)
    );

    for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
        assign ro_words[i] = ro_in[32*i +: 32];
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        assign regs_out[32*i +: 32] = regs_q[i];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        ack       = 1'b0;
        err       = 1'b0;
        strobe_wr = 1'b0;
        unique case (state_q)
            StIdle:   ;
            StAccess: strobe_wr = we_q;
            StResp: begin
                ack = 1'b1;
                err = err_q;
            end
            default:  ;
        endcase
    end

    assign rdata   = rdata_q;
    assign addr_wr = addr_wr_q;
    assign data_wr = data_wr_q;

    // Readback mux; local registers win over every other window.
    always_comb begin
        rdata_d = RD_UNMAPPED;
        if (hit_local) begin
            rdata_d = regs_q[local_idx];
        end else if (hit_ro) begin
            rdata_d = ro_words[ro_idx];
        end else if (hit_errcnt) begin
            rdata_d = 32'(err_cnt);
        end
    end

    // Writes into the RO window are still errors even though they reach the settings bus.
    assign err_d = !(hit_local || hit_errcnt || (hit_ro && !we_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            addr_wr_q <= '0;
            data_wr_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            if (state_q == StIdle && req) begin
                addr_q  <= addr;
                we_q    <= we;
                wdata_q <= wdata;
                if (we) begin
                    addr_wr_q <= addr;
                    data_wr_q <= wdata;
                end
            end
            if (state_q == StAccess) begin
                err_q <= err_d;
                if (!we_q) begin
                    rdata_q <= rdata_d;
                end else if (hit_local) begin
                    regs_q[local_idx] <= wdata_q;
                end
            end
        end
    end

`ifdef REGIO_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (state_q == StAccess && we_q && hit_errcnt) begin
            err_cnt_q <= '0;
        end else if (state_q == StResp && err_q && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_register_io_bank.sv
// Directed self-checking bench for register_io_bank with default parameters.
module tb_register_io_bank;

    logic         clk;
    logic         reset;
    logic         req;
    logic         we;
    logic [6:0]   addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         ack;
    logic         err;
    logic [127:0] ro_in;
    logic [63:0]  regs_out;
    logic         strobe_wr;
    logic [6:0]   addr_wr;
    logic [31:0]  data_wr;

    int checks = 0;
    int errors = 0;

    register_io_bank dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ack      (ack),
        .err      (err),
        .ro_in    (ro_in),
        .regs_out (regs_out),
        .strobe_wr(strobe_wr),
        .addr_wr  (addr_wr),
        .data_wr  (data_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept edge, ACCESS, RESP, back to IDLE.
    task automatic access(input string tag, input logic w, input logic [6:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic e);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        chk({tag, "/ack_access"}, 32'(ack), 32'd0);
        chk({tag, "/strobe"}, 32'(strobe_wr), 32'(w));
        if (w) begin
            chk({tag, "/addr_wr"}, 32'(addr_wr), 32'(a));
            chk({tag, "/data_wr"}, data_wr, d);
        end
        @(posedge clk); #1;
        chk({tag, "/ack_resp"}, 32'(ack), 32'd1);
        rd = rdata;
        e  = err;
        @(posedge clk); #1;
        chk({tag, "/ack_idle"}, 32'(ack), 32'd0);
        chk({tag, "/strobe_idle"}, 32'(strobe_wr), 32'd0);
    endtask

    logic [31:0] rd;
    logic        e;
    int          acks;

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; ro_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/ack", 32'(ack), 32'd0);
        chk("rst/err", 32'(err), 32'd0);
        chk("rst/rdata", rdata, 32'h0);
        chk("rst/strobe", 32'(strobe_wr), 32'd0);
        chk("rst/addr_wr", 32'(addr_wr), 32'd0);
        chk("rst/data_wr", data_wr, 32'h0);
        chk("rst/regs0", regs_out[31:0], 32'h0);
        chk("rst/regs1", regs_out[63:32], 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: read reset value of local reg 0
        access("rd51", 1'b0, 7'd51, 32'h0, rd, e);
        chk("rd51/rdata", rd, 32'h0);
        chk("rd51/err", 32'(e), 32'd0);

        // Test 2: write and read back local reg 1
        access("wr52", 1'b1, 7'd52, 32'hDEAD_BEEF, rd, e);
        chk("wr52/err", 32'(e), 32'd0);
        chk("wr52/rdata_kept", rd, 32'h0);
        chk("wr52/addr_wr_held", 32'(addr_wr), 32'd52);
        chk("wr52/regs1", regs_out[63:32], 32'hDEAD_BEEF);
        chk("wr52/regs0", regs_out[31:0], 32'h0);
        access("rd52", 1'b0, 7'd52, 32'h0, rd, e);
        chk("rd52/rdata", rd, 32'hDEAD_BEEF);
        chk("rd52/err", 32'(e), 32'd0);

        // Test 3: read-only window, including both edges
        ro_in[31:0]   = 32'hA5A5_0001;
        ro_in[95:64]  = 32'h1234_5678;
        ro_in[127:96] = 32'hCAFE_F00D;
        access("rd3", 1'b0, 7'd3, 32'h0, rd, e);
        chk("rd3/rdata", rd, 32'h1234_5678);
        chk("rd3/err", 32'(e), 32'd0);
        access("wr3", 1'b1, 7'd3, 32'h0, rd, e);
        chk("wr3/err", 32'(e), 32'd1);
        chk("wr3/rdata_kept", rd, 32'h1234_5678);
        access("rd3b", 1'b0, 7'd3, 32'h0, rd, e);
        chk("rd3b/rdata", rd, 32'h1234_5678);
        access("rd1", 1'b0, 7'd1, 32'h0, rd, e);
        chk("rd1/rdata", rd, 32'hA5A5_0001);
        access("rd4", 1'b0, 7'd4, 32'h0, rd, e);
        chk("rd4/rdata", rd, 32'hCAFE_F00D);
        chk("rd4/err", 32'(e), 32'd0);
        access("rd5", 1'b0, 7'd5, 32'h0, rd, e);
        chk("rd5/rdata", rd, 32'hFFFF_FFFF);
        chk("rd5/err", 32'(e), 32'd1);
        access("rd50", 1'b0, 7'd50, 32'h0, rd, e);
        chk("rd50/rdata", rd, 32'hFFFF_FFFF);
        chk("rd50/err", 32'(e), 32'd1);

        // Test 4: unmapped read and write
        access("rd60", 1'b0, 7'd60, 32'h0, rd, e);
        chk("rd60/rdata", rd, 32'hFFFF_FFFF);
        chk("rd60/err", 32'(e), 32'd1);
        access("wr60", 1'b1, 7'd60, 32'h5, rd, e);
        chk("wr60/err", 32'(e), 32'd1);
        chk("wr60/regs0", regs_out[31:0], 32'h0);
        chk("wr60/regs1", regs_out[63:32], 32'hDEAD_BEEF);

        // Test 5: reset during ACCESS aborts the pending write
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 7'd51; wdata = 32'h1;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        chk("abort/strobe", 32'(strobe_wr), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort/ack", 32'(ack), 32'd0);
        chk("abort/strobe_after", 32'(strobe_wr), 32'd0);
        chk("abort/regs0", regs_out[31:0], 32'h0);
        chk("abort/regs1", regs_out[63:32], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort/ack_later", 32'(ack), 32'd0);

        // req held through ACCESS and RESP must yield exactly one ack
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 7'd51; wdata = 32'h7;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
            if (i == 2) begin
                req = 1'b0; we = 1'b0;
            end
        end
        chk("held/acks", 32'(acks), 32'd1);
        chk("held/regs0", regs_out[31:0], 32'h7);

        // Test 6: error counter window
`ifdef REGIO_ERR_CNT_EN
        access("cnt_a", 1'b0, 7'd70, 32'h0, rd, e);
        access("cnt_b", 1'b0, 7'd0, 32'h0, rd, e);
        access("cnt_c", 1'b0, 7'd127, 32'h0, rd, e);
        chk("cnt_c/err", 32'(e), 32'd1);
        access("rd53", 1'b0, 7'd53, 32'h0, rd, e);
        chk("rd53/rdata", rd, 32'h3);
        chk("rd53/err", 32'(e), 32'd0);
        access("wr53", 1'b1, 7'd53, 32'h1234, rd, e);
        chk("wr53/err", 32'(e), 32'd0);
        access("rd53b", 1'b0, 7'd53, 32'h0, rd, e);
        chk("rd53b/rdata", rd, 32'h0);
`else
        access("rd53", 1'b0, 7'd53, 32'h0, rd, e);
        chk("rd53/rdata", rd, 32'hFFFF_FFFF);
        chk("rd53/err", 32'(e), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
